// File: rtl/zeroheti_pkg.sv
// Shared register map, CTRL layout and register-read helpers for the ZeroHeti APB timer group.
package zeroheti_pkg;

  localparam logic [3:0]  CTRL_OFFSET   = 4'h0;
  localparam logic [3:0]  COUNT_OFFSET  = 4'h4;
  localparam logic [3:0]  CMP_OFFSET    = 4'h8;
  localparam logic [3:0]  STATUS_OFFSET = 4'hC;
  localparam logic [31:0] CMP_RESET     = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [7:0] presc;
    logic       ie;
    logic       autoreload;
    logic       en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_to_word(input ctrl_t ctrl);
    return {16'h0000, ctrl.presc, 5'b00000, ctrl.ie, ctrl.autoreload, ctrl.en};
  endfunction

  function automatic logic [31:0] channel_read(
    input logic [3:0]  off,
    input ctrl_t       ctrl,
    input logic [31:0] count,
    input logic [31:0] cmp,
    input logic        pending
  );
    logic [31:0] word;
    case (off)
      CTRL_OFFSET:   word = ctrl_to_word(ctrl);
      COUNT_OFFSET:  word = count;
      CMP_OFFSET:    word = cmp;
      STATUS_OFFSET: word = {31'd0, pending};
      default:       word = 32'h0000_0000;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/apb_if.sv
// 32-bit APB bus bundle; the timer group attaches through the Slave modport.
interface APB;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport Slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );

  modport Master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );
endinterface

// File: rtl/zeroheti_timer_channel.sv
// One timer channel: prescaler (only with ZEROHETI_TG_PRESCALER_EN), 32-bit up-counter,
// compare match and a write-1-to-clear pending flag driving a level interrupt.
module zeroheti_timer_channel
  import zeroheti_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ctrl_we,
  input  logic        count_we,
  input  logic        cmp_we,
  input  logic        status_we,
  input  logic [31:0] wdata,
  output ctrl_t       ctrl,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic        pending,
  output logic        irq
);

  logic        en_r;
  logic        autoreload_r;
  logic        ie_r;
  logic        pending_r;
  logic [31:0] count_r;
  logic [31:0] cmp_r;
  logic        tick_s;
  logic        match_s;

  // Control bits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_r         <= 1'b0;
      autoreload_r <= 1'b0;
      ie_r         <= 1'b0;
    end else if (ctrl_we) begin
      en_r         <= wdata[0];
      autoreload_r <= wdata[1];
      ie_r         <= wdata[2];
    end
  end

`ifdef ZEROHETI_TG_PRESCALER_EN
  logic [7:0] presc_r;
  logic [7:0] presc_cnt_r;

  // Prescale divisor
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_r <= 8'h00;
    end else if (ctrl_we) begin
      presc_r <= wdata[15:8];
    end
  end

  // Prescale counter: restarts only when the channel is switched off, never on other CTRL writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_cnt_r <= 8'h00;
    end else if (ctrl_we && en_r && !wdata[0]) begin
      presc_cnt_r <= 8'h00;
    end else if (!en_r || tick_s) begin
      presc_cnt_r <= 8'h00;
    end else begin
      presc_cnt_r <= presc_cnt_r + 8'd1;
    end
  end

  assign tick_s = en_r && (presc_cnt_r == presc_r);
  assign ctrl   = '{presc: presc_r, ie: ie_r, autoreload: autoreload_r, en: en_r};
`else
  assign tick_s = en_r;
  assign ctrl   = '{presc: 8'h00, ie: ie_r, autoreload: autoreload_r, en: en_r};
`endif

  assign match_s = (count_r == cmp_r);

  // Counter: a bus write beats the tick in the same cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r <= 32'h0000_0000;
    end else if (count_we) begin
      count_r <= wdata;
    end else if (tick_s) begin
      count_r <= (match_s && autoreload_r) ? 32'h0000_0000 : count_r + 32'd1;
    end
  end

  // Compare value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_r <= CMP_RESET;
    end else if (cmp_we) begin
      cmp_r <= wdata;
    end
  end

  // Pending flag: a match in the same cycle as a W1C keeps it set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_r <= 1'b0;
    end else if (tick_s && match_s) begin
      pending_r <= 1'b1;
    end else if (status_we && wdata[0]) begin
      pending_r <= 1'b0;
    end
  end

  assign count   = count_r;
  assign cmp     = cmp_r;
  assign pending = pending_r;
  assign irq     = pending_r & ie_r;

endmodule

// File: rtl/zeroheti_apb_timer.sv
// APB timer group: NumTimers channels in 16-byte windows, zero-wait-state access.
// Optional prescaler per channel is built only with ZEROHETI_TG_PRESCALER_EN defined.
module zeroheti_apb_timer
  import zeroheti_pkg::*;
#(
  parameter int unsigned NumTimers = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  APB.Slave                    apb_sbr,
  output logic [NumTimers-1:0] irq_o
);

  logic [2:0]                  ch_idx_s;
  logic [3:0]                  reg_off_s;
  logic                        ch_valid_s;
  logic                        access_s;
  logic                        wr_en_s;
  logic [31:0]                 rdata_s;
  logic [NumTimers-1:0][31:0]  ch_rdata_s;
  logic                        unused_addr_s;

  // Bits above the channel windows and the byte offset within a word are don't-care
  assign ch_idx_s      = apb_sbr.paddr[6:4];
  assign reg_off_s     = {apb_sbr.paddr[3:2], 2'b00};
  assign unused_addr_s = ^{apb_sbr.paddr[31:7], apb_sbr.paddr[1:0]};
  assign ch_valid_s    = ({29'd0, ch_idx_s} < NumTimers);
  assign access_s      = apb_sbr.psel && apb_sbr.penable;
  assign wr_en_s       = access_s && apb_sbr.pwrite && ch_valid_s;

  for (genvar i = 0; i < NumTimers; i++) begin : g_ch
    logic        sel_s;
    ctrl_t       ctrl_s;
    logic [31:0] count_s;
    logic [31:0] cmp_s;
    logic        pending_s;

    assign sel_s = wr_en_s && (ch_idx_s == 3'(i));

    zeroheti_timer_channel u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .ctrl_we   (sel_s && (reg_off_s == CTRL_OFFSET)),
      .count_we  (sel_s && (reg_off_s == COUNT_OFFSET)),
      .cmp_we    (sel_s && (reg_off_s == CMP_OFFSET)),
      .status_we (sel_s && (reg_off_s == STATUS_OFFSET)),
      .wdata     (apb_sbr.pwdata),
      .ctrl      (ctrl_s),
      .count     (count_s),
      .cmp       (cmp_s),
      .pending   (pending_s),
      .irq       (irq_o[i])
    );

    assign ch_rdata_s[i] = channel_read(reg_off_s, ctrl_s, count_s, cmp_s, pending_s);
  end

  // Read mux: OR of the selected channel's word
  always_comb begin
    rdata_s = 32'h0000_0000;
    for (int unsigned i = 0; i < NumTimers; i++) begin
      rdata_s = rdata_s | ((ch_idx_s == 3'(i)) ? ch_rdata_s[i] : 32'h0000_0000);
    end
  end

  assign apb_sbr.prdata  = (apb_sbr.psel && ch_valid_s) ? rdata_s : 32'h0000_0000;
  assign apb_sbr.pready  = 1'b1;
  assign apb_sbr.pslverr = access_s && !ch_valid_s;

endmodule

// File: tb/tb_zeroheti_apb_timer.sv
// Directed scoreboard bench for zeroheti_apb_timer (NumTimers=2); expectations follow the build macro.
module tb_zeroheti_apb_timer;

`ifdef ZEROHETI_TG_PRESCALER_EN
  localparam int          IrqCycles  = 21;
  localparam logic [31:0] CountAfter = 32'h0000_0000;
  localparam logic [31:0] CtrlRead   = 32'h0000_0307;
`else
  localparam int          IrqCycles  = 6;
  localparam logic [31:0] CountAfter = 32'h0000_0002;
  localparam logic [31:0] CtrlRead   = 32'h0000_0007;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        slverr;
    logic        is_read;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] irq;
  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];

  APB apb_bus ();

  zeroheti_apb_timer #(.NumTimers(2)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .apb_sbr (apb_bus),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  // Monitor: every completed access phase is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && apb_bus.psel && apb_bus.penable && apb_bus.pready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL apb_unexpected addr=%h", apb_bus.paddr);
      end else begin
        e = exp_q.pop_front();
        if (apb_bus.paddr !== e.addr || apb_bus.pslverr !== e.slverr ||
            (e.is_read && apb_bus.prdata !== e.rdata)) begin
          errors++;
          $display("FAIL apb_xfer addr=%h got rdata=%h slverr=%b want addr=%h rdata=%h slverr=%b",
                   apb_bus.paddr, apb_bus.prdata, apb_bus.pslverr, e.addr, e.rdata, e.slverr);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    e.addr = addr; e.rdata = exp_rdata; e.slverr = exp_err; e.is_read = !wr;
    exp_q.push_back(e);
    apb_bus.psel = 1'b1; apb_bus.penable = 1'b0; apb_bus.pwrite = wr;
    apb_bus.paddr = addr; apb_bus.pwdata = wdata;
    @(posedge clk); #1;
    apb_bus.penable = 1'b1;
    @(posedge clk); #1;
    apb_bus.psel = 1'b0; apb_bus.penable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    apb_xfer(1'b1, addr, data, 32'h0000_0000, 1'b0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] want);
    apb_xfer(1'b0, addr, 32'h0000_0000, want, 1'b0);
  endtask

  task automatic idle_check();
    #1;
    check("idle_prdata", apb_bus.prdata, 32'h0000_0000);
    check("idle_pslverr", 32'(apb_bus.pslverr), 32'h0000_0000);
    check("idle_pready", 32'(apb_bus.pready), 32'h0000_0001);
  endtask

  // Counts cycles after the enabling write until irq[ch] is first seen high
  task automatic wait_irq(input int ch, input int want_cycles, input string name);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (irq[ch]) break;
    end
    check(name, 32'(n), 32'(want_cycles));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    apb_bus.psel = 1'b0; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0;
    apb_bus.paddr = 32'h0000_0000; apb_bus.pwdata = 32'h0000_0000;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset sweep
    check("reset_irq", 32'(irq), 32'h0000_0000);
    for (int ch = 0; ch < 2; ch++) begin
      for (int r = 0; r < 4; r++) begin
        rd(32'(ch * 16 + r * 4), (r == 2) ? 32'hFFFF_FFFF : 32'h0000_0000);
      end
    end
    idle_check();

    // Out-of-range channel: error, read 0, write ignored; high address bits alias
    apb_xfer(1'b0, 32'h0000_0024, 32'h0000_0000, 32'h0000_0000, 1'b1);
    apb_xfer(1'b1, 32'h0000_0024, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1);
    apb_xfer(1'b1, 32'h0000_0028, 32'h1234_5678, 32'h0000_0000, 1'b1);
    rd(32'h0000_0004, 32'h0000_0000);
    rd(32'h0000_0014, 32'h0000_0000);
    rd(32'h0000_0008, 32'hFFFF_FFFF);
    rd(32'h1000_0018, 32'hFFFF_FFFF);
    idle_check();

    // Prescaled match with autoreload on channel 0 (reserved CTRL bits written as 1)
    wr(32'h0000_0008, 32'h0000_0004);
    wr(32'h0000_0000, 32'hFFFF_03FF);
    wait_irq(0, IrqCycles, "irq0_prescaled_match");
    rd(32'h0000_0004, CountAfter);
    rd(32'h0000_000C, 32'h0000_0001);
    rd(32'h0000_0000, CtrlRead);

    // W1C clears; CMP write leaves pending alone
    wr(32'h0000_0000, 32'h0000_0000);
    check("irq0_ie_off", 32'(irq[0]), 32'h0000_0000);
    wr(32'h0000_000C, 32'h0000_0001);
    rd(32'h0000_000C, 32'h0000_0000);
    wr(32'h0000_0004, 32'h0000_0000);
    wr(32'h0000_0008, 32'h0000_0000);
    rd(32'h0000_000C, 32'h0000_0000);

    // COUNT==CMP==0 with autoreload matches every tick, so the W1C collides with a set
    wr(32'h0000_0000, 32'h0000_0007);
    wr(32'h0000_000C, 32'h0000_0001);
    check("irq0_w1c_collision", 32'(irq[0]), 32'h0000_0001);
    rd(32'h0000_000C, 32'h0000_0001);

    // COUNT write overrides the tick: 0x10 lands, the next tick makes it 0x11 at read time
    wr(32'h0000_0008, 32'hFFFF_FFFF);
    wr(32'h0000_0004, 32'h0000_0010);
    rd(32'h0000_0004, 32'h0000_0011);
    wr(32'h0000_0000, 32'h0000_0000);
    rd(32'h0000_0004, 32'h0000_0014);
    repeat (3) @(posedge clk); #1;
    rd(32'h0000_0004, 32'h0000_0014);
    wr(32'h0000_000C, 32'h0000_0001);
    rd(32'h0000_000C, 32'h0000_0000);

    // Wrap-around on channel 1: two ticks reach 0, then six more ticks to the match
    wr(32'h0000_0014, 32'hFFFF_FFFE);
    wr(32'h0000_0018, 32'h0000_0005);
    wr(32'h0000_0010, 32'h0000_0005);
    wr(32'h0000_0010, 32'h0000_0004);
    rd(32'h0000_0014, 32'h0000_0000);
    check("irq1_before_match", 32'(irq[1]), 32'h0000_0000);
    wr(32'h0000_0010, 32'h0000_0005);
    wait_irq(1, 7, "irq1_wrap_match");
    rd(32'h0000_001C, 32'h0000_0001);

    // Reset while counting with pending set: irq must fall before the next clock edge
    @(posedge clk); #3;
    check("irq1_before_reset", 32'(irq[1]), 32'h0000_0001);
    rst_n = 1'b0;
    #1;
    check("irq_async_reset", 32'(irq), 32'h0000_0000);
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(32'h0000_001C, 32'h0000_0000);
    rd(32'h0000_0018, 32'hFFFF_FFFF);
    rd(32'h0000_0010, 32'h0000_0000);
    rd(32'h0000_0014, 32'h0000_0000);
    check("irq_after_reset", 32'(irq), 32'h0000_0000);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0000_0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
